// File: rtl/lab62_soc_debug_mem_access.sv
// OCI debug memory access engine: turns debug-slave strobes into single-word
// Avalon-MM reads/writes and reports read data and status back for shift-out.
module lab62_soc_debug_mem_access #(
  parameter int AW      = 26,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  output logic [AW-1:0] avm_address,
  output logic          avm_read,
  output logic          avm_write,
  output logic [31:0]   avm_writedata,
  output logic [3:0]    avm_byteenable,
  input  logic [31:0]   avm_readdata,
  input  logic          avm_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] addr;
  logic [15:0]   tcnt;
  logic          rd_incr;
  logic          any_strobe;
  logic          stall_to;
  logic          unused_jdo;

  assign any_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // This stalled cycle is the TIMEOUT-th one; a completing cycle never aborts.
  assign stall_to       = avm_waitrequest && (tcnt == 16'(TIMEOUT - 1));
  assign avm_address    = addr;
  assign avm_byteenable = 4'hF;
  assign unused_jdo     = ^{jdo[37:35], jdo[1:0]};

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (take_action_ocimem_b)                                 state_d = WR;
        else if (take_action_ocimem_a || take_no_action_ocimem_a) state_d = RD;
      end
      RD, WR: if (!avm_waitrequest || stall_to) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      tcnt          <= '0;
      rd_incr       <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (any_strobe) begin
          monitor_error <= 1'b0;
          monitor_ready <= 1'b0;
          tcnt          <= '0;
          if (take_action_ocimem_b) begin
            avm_writedata <= jdo[34:3];
            avm_write     <= 1'b1;
          end else if (take_action_ocimem_a) begin
            addr     <= {jdo[AW-1:2], 2'b00};
            avm_read <= 1'b1;
            rd_incr  <= 1'b0;
          end else begin
            avm_read <= 1'b1;
            rd_incr  <= 1'b1;
          end
        end
        RD: begin
          if (!avm_waitrequest) begin
            MonDReg  <= avm_readdata;
            avm_read <= 1'b0;
            if (rd_incr) addr <= addr + AW'(4);
          end else if (stall_to) begin
            avm_read      <= 1'b0;
            monitor_error <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        WR: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            addr      <= addr + AW'(4);
          end else if (stall_to) begin
            avm_write     <= 1'b0;
            monitor_error <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DONE:    monitor_ready <= 1'b1;
        default: ;
      endcase
      // Strobes while busy are dropped but flagged; the transfer carries on.
      if (state != IDLE && any_strobe) monitor_error <= 1'b1;
    end
  end

endmodule

// File: doc/lab62_soc_debug_mem_access.md
Name: lab62_soc_debug_mem_access

Overview:
- Executes OCI memory commands from the JTAG debug slave: the one-cycle take_action/take_no_action strobes and the jdo payload produced in the system-clock domain.
- Runs word reads/writes over an Avalon-MM master into system memory.
- Returns read data and status (MonDReg, monitor_ready, monitor_error) to the debug slave for shift-out.
- Sits directly downstream of the debug slave wrapper, in the clk domain.

Parameters:
- AW, 26: byte-address width of the Avalon master; word aligned, bits [1:0] always 0.
- TIMEOUT, 255: maximum cycles a transfer may stall on avm_waitrequest before it is aborted; 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  command payload; valid in the cycle a strobe is high.
- take_action_ocimem_a  in  1  load address, then read.
- take_no_action_ocimem_a  in  1  read at the current address, then auto-increment.
- take_action_ocimem_b  in  1  write, then auto-increment.
- avm_address  out  AW  byte address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_readdata  in  32  read data; valid when avm_read=1 and avm_waitrequest=0.
- avm_waitrequest  in  1  slave stall.
- MonDReg  out  32  last read data.
- monitor_ready  out  1  high when idle and the last command completed.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous, active-high.
  - Reset values: state=IDLE, addr=0, MonDReg=0, monitor_ready=1, monitor_error=0, avm_read=0, avm_write=0, avm_writedata=0, timeout counter=0.
  - Reset mid-transfer deasserts avm_read/avm_write on the next edge; the transfer is abandoned.
- Command decode (accepted only in IDLE):
  - ocimem_a: addr <= {jdo[AW-1:2], 2'b00}, then read.
  - no_action_ocimem_a: read at addr.
  - ocimem_b: avm_writedata <= jdo[34:3], then write at addr.
  - Simultaneous strobes: priority ocimem_b > ocimem_a > no_action_ocimem_a; lower-priority strobes in that cycle are discarded.
  - Acceptance clears monitor_error and drives monitor_ready=0 on the next edge.
- States:
  - IDLE: no request asserted. An accepted read goes to RD; an accepted write goes to WR. avm_read/avm_write assert in the cycle after the strobe.
  - RD: avm_read=1 and avm_address=addr held stable until avm_waitrequest=0.
    - On that cycle: MonDReg <= avm_readdata, avm_read <= 0, go to DONE.
    - Address increment after completion applies to no_action_ocimem_a only. ocimem_a does not increment.
  - WR: avm_write=1; address and data held stable until avm_waitrequest=0. Then avm_write <= 0, addr <= addr+4, go to DONE.
  - DONE: monitor_ready <= 1, return to IDLE (one cycle).
- Latency: with zero wait states, a strobe at cycle N gives a request in N+1, completion in N+1, and monitor_ready=1 at N+3.
- Address increment:
  - Modulo 2^AW: the all-ones word address wraps to 0.
  - Bits [1:0] forced to 0.
- Timeout:
  - The counter increments on every RD/WR cycle with avm_waitrequest=1.
  - When the count reaches TIMEOUT: deassert the request, set monitor_error=1, leave MonDReg and addr unchanged, go to DONE.
  - A completion in the same cycle the count reaches TIMEOUT counts as success.
- Busy collision:
  - Any strobe arriving outside IDLE is dropped and sets monitor_error=1.
  - The in-flight transfer continues unaffected. The error stays set through its DONE and is cleared only by the next accepted command.
- Outputs are all registered; no combinational path from strobes or avm inputs to outputs.

Test Plan:
- Reset, then ocimem_a with jdo[25:2] giving address 0x0001000; slave returns 0xCAFEF00D with 0 waits -> avm_read for exactly 1 cycle at 0x0001000; MonDReg=0xCAFEF00D; monitor_ready rises 3 cycles after the strobe; addr stays 0x0001000.
- ocimem_b with jdo[34:3]=0x12345678, then no_action_ocimem_a, slave holding waitrequest for 5 cycles each time -> write of 0x12345678 to A, byteenable=F, signals stable for 6 cycles; read issued at A+4.
- Address at 0x3FFFFFC (AW=26), then no_action_ocimem_a -> read completes, addr wraps to 0x0000000; the next read is issued at 0.
- Waitrequest held high forever with TIMEOUT=255 -> request drops after 255 stalled cycles; monitor_error=1, MonDReg unchanged, monitor_ready=1; the next accepted command clears the error.
- ocimem_a and ocimem_b strobed in the same cycle -> only the write executes. A strobe during the write's stall cycles -> dropped, monitor_error=1 after completion.
- Reset asserted during a 10-cycle stalled read -> avm_read=0 on the next edge; all outputs at reset values; a new command then executes normally.
